// File: rtl/branch_predict_ctrl_if.sv
// Decode/execute control-transfer bus between the pipeline (master) and branch_predict_ctrl (slave).
// Pure wiring with no flow control; the D-stage signals and the E-stage resolution share one bundle.
interface branch_predict_ctrl_if #(
   parameter int STAT_W = 16
);
   logic [31:0]       d_instr;
   logic [31:0]       d_pc;
   logic              d_valid;
   logic              stall;
   logic              br;
   logic              is_cond;
   logic              extctr;
   logic              pred_taken;
   logic              Dclr;
   logic              e_resolve;
   logic [31:0]       e_pc;
   logic              e_taken;
   logic              e_pred;
   logic              mispredict;
   logic              stat_clr;
   logic [STAT_W-1:0] br_cnt;
   logic [STAT_W-1:0] miss_cnt;

   modport master (
      output d_instr, d_pc, d_valid, stall, e_resolve, e_pc, e_taken, e_pred, stat_clr,
      input  br, is_cond, extctr, pred_taken, Dclr, mispredict, br_cnt, miss_cnt
   );

   modport slave (
      input  d_instr, d_pc, d_valid, stall, e_resolve, e_pc, e_taken, e_pred, stat_clr,
      output br, is_cond, extctr, pred_taken, Dclr, mispredict, br_cnt, miss_cnt
   );
endinterface

// File: rtl/branch_predict_ctrl.sv
// D-stage branch decode and counter-table prediction, trained from E-stage resolution.
// Decode/predict/mispredict are zero-cycle; table and statistics update on the next edge; no backpressure.
module branch_predict_ctrl #(
   parameter int BHT_DEPTH = 64,
   parameter int CNT_W     = 2,
   parameter int IDX_LSB   = 2,
   parameter int STAT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   branch_predict_ctrl_if.slave bus
);
   localparam int              IDX_W   = $clog2(BHT_DEPTH);
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((2 ** (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [CNT_W-1:0]  tbl [BHT_DEPTH];
   logic [IDX_W-1:0]  d_idx;
   logic [IDX_W-1:0]  e_idx;
   logic [5:0]        op;
   logic [5:0]        funct;
   logic [4:0]        rt;
   logic              cond_raw;
   logic              uncond_raw;
   logic              eret_raw;
   logic              ext_raw;
   logic [STAT_W-1:0] br_cnt_q;
   logic [STAT_W-1:0] miss_cnt_q;
   logic              miss;
   logic              unused_bits;

   assign op    = bus.d_instr[31:26];
   assign rt    = bus.d_instr[20:16];
   assign funct = bus.d_instr[5:0];
   assign d_idx = bus.d_pc[IDX_LSB +: IDX_W];
   assign e_idx = bus.e_pc[IDX_LSB +: IDX_W];

   always_comb begin
      cond_raw   = 1'b0;
      uncond_raw = 1'b0;
      eret_raw   = 1'b0;
      ext_raw    = 1'b0;
      case (op)
         6'b000100, 6'b000101, 6'b000110, 6'b000111: cond_raw = 1'b1;
         6'b000001: cond_raw = (rt == 5'b00000) || (rt == 5'b00001);
         6'b000010, 6'b000011: uncond_raw = 1'b1;
         6'b000000: uncond_raw = (funct == 6'b001000) || (funct == 6'b001001);
         6'b010000: begin
            eret_raw   = bus.d_instr[25] && (funct == 6'b011000);
            uncond_raw = bus.d_instr[25] && (funct == 6'b011000);
         end
         6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
         6'b101011, 6'b101000, 6'b101001,
         6'b001000, 6'b001001, 6'b001010, 6'b001011: ext_raw = 1'b1;
         default: ;
      endcase
   end

   assign bus.br         = bus.d_valid & (cond_raw | uncond_raw);
   assign bus.is_cond    = bus.d_valid & cond_raw;
   assign bus.extctr     = ext_raw;
   // Lookup reads the stored value, so a same-cycle training write is seen only next cycle.
   assign bus.pred_taken = cond_raw ? tbl[d_idx][CNT_W-1] : uncond_raw;
   assign bus.Dclr       = eret_raw & bus.d_valid & ~bus.stall;

   assign miss           = bus.e_resolve & (bus.e_taken != bus.e_pred);
   assign bus.mispredict = miss;
   assign bus.br_cnt     = br_cnt_q;
   assign bus.miss_cnt   = miss_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            tbl[i] <= CNT_RST;
         end
      end else if (bus.e_resolve) begin
         if (bus.e_taken) begin
            if (tbl[e_idx] != CNT_MAX) tbl[e_idx] <= tbl[e_idx] + CNT_W'(1);
         end else begin
            if (tbl[e_idx] != '0) tbl[e_idx] <= tbl[e_idx] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else if (bus.stat_clr) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (bus.e_resolve && (br_cnt_q != STAT_MAX)) br_cnt_q <= br_cnt_q + STAT_W'(1);
         if (miss && (miss_cnt_q != STAT_MAX))        miss_cnt_q <= miss_cnt_q + STAT_W'(1);
      end
   end

   // Only the decode fields and index bits matter; the rest of the buses is ignored.
   assign unused_bits = ^{bus.d_instr, bus.d_pc, bus.e_pc};
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench: decode vector table, training/saturation, read-before-write, statistics, async reset, aliasing.
module tb_branch_predict_ctrl;
   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   passed = 0;

   always #5 clk = ~clk;

   branch_predict_ctrl_if #(.STAT_W(4)) ifa ();
   branch_predict_ctrl_if #(.STAT_W(4)) ifb ();

   branch_predict_ctrl #(.BHT_DEPTH(64), .CNT_W(2), .IDX_LSB(2), .STAT_W(4)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa));
   branch_predict_ctrl #(.BHT_DEPTH(4), .CNT_W(2), .IDX_LSB(2), .STAT_W(4)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb));

   typedef struct {
      logic [31:0] instr;
      logic        valid;
      logic        stall;
      logic        chk_pred;
      logic [4:0]  exp;   // {br, is_cond, extctr, pred_taken, Dclr}
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask

   task automatic add_vec(input logic [31:0] instr, input logic valid, input logic stall,
                          input logic chk_pred, input logic [4:0] exp);
      vec_t v;
      v.instr = instr; v.valid = valid; v.stall = stall; v.chk_pred = chk_pred; v.exp = exp;
      vq.push_back(v);
   endtask

   // Called at posedge+1; holds the resolve across exactly one rising edge.
   task automatic resolve(input bit on_b, input logic [31:0] pc, input logic taken, input logic pred);
      if (on_b) begin
         ifb.e_resolve = 1'b1; ifb.e_pc = pc; ifb.e_taken = taken; ifb.e_pred = pred;
      end else begin
         ifa.e_resolve = 1'b1; ifa.e_pc = pc; ifa.e_taken = taken; ifa.e_pred = pred;
      end
      @(posedge clk); #1;
      ifa.e_resolve = 1'b0;
      ifb.e_resolve = 1'b0;
   endtask

   task automatic lookup_a(input string name, input logic [31:0] pc, input logic exp);
      ifa.d_instr = 32'h14000000; ifa.d_pc = pc; ifa.d_valid = 1'b1;
      #1 chk(name, {31'd0, ifa.pred_taken}, {31'd0, exp});
   endtask

   task automatic lookup_b(input string name, input logic [31:0] pc, input logic exp);
      ifb.d_instr = 32'h10000000; ifb.d_pc = pc; ifb.d_valid = 1'b1;
      #1 chk(name, {31'd0, ifb.pred_taken}, {31'd0, exp});
   endtask

   task automatic idle_all();
      ifa.d_instr = '0; ifa.d_pc = '0; ifa.d_valid = 0; ifa.stall = 0;
      ifa.e_resolve = 0; ifa.e_pc = '0; ifa.e_taken = 0; ifa.e_pred = 0; ifa.stat_clr = 0;
      ifb.d_instr = '0; ifb.d_pc = '0; ifb.d_valid = 0; ifb.stall = 0;
      ifb.e_resolve = 0; ifb.e_pc = '0; ifb.e_taken = 0; ifb.e_pred = 0; ifb.stat_clr = 0;
   endtask

   initial begin
      logic [4:0] act;
      logic [4:0] exp;
      reset = 1'b0;
      idle_all();

      // Fresh counters are weakly not-taken, so conditional rows predict 0.
      add_vec(32'h10000000, 1, 0, 1, 5'b11000); // beq
      add_vec(32'h14000000, 1, 0, 1, 5'b11000); // bne
      add_vec(32'h18000000, 1, 0, 1, 5'b11000); // blez
      add_vec(32'h1C000000, 1, 0, 1, 5'b11000); // bgtz
      add_vec(32'h04000000, 1, 0, 1, 5'b11000); // bltz
      add_vec(32'h04010000, 1, 0, 1, 5'b11000); // bgez
      add_vec(32'h04020000, 1, 0, 1, 5'b00000); // regimm rt=2
      add_vec(32'h08000000, 1, 0, 1, 5'b10010); // j
      add_vec(32'h0C000000, 1, 0, 1, 5'b10010); // jal
      add_vec(32'h03E00008, 1, 0, 1, 5'b10010); // jr
      add_vec(32'h00000009, 1, 0, 1, 5'b10010); // jalr
      add_vec(32'h00000020, 1, 0, 1, 5'b00000); // add
      add_vec(32'h42000018, 1, 0, 1, 5'b10011); // eret
      add_vec(32'h42000018, 1, 1, 1, 5'b10010); // eret stalled
      add_vec(32'h40000018, 1, 0, 1, 5'b00000); // op 010000 without bit 25
      add_vec(32'h8C000000, 1, 0, 1, 5'b00100); // lw
      add_vec(32'h80000000, 1, 0, 1, 5'b00100); // lb
      add_vec(32'h90000000, 1, 0, 1, 5'b00100); // lbu
      add_vec(32'h84000000, 1, 0, 1, 5'b00100); // lh
      add_vec(32'h94000000, 1, 0, 1, 5'b00100); // lhu
      add_vec(32'hAC000000, 1, 0, 1, 5'b00100); // sw
      add_vec(32'hA0000000, 1, 0, 1, 5'b00100); // sb
      add_vec(32'hA4000000, 1, 0, 1, 5'b00100); // sh
      add_vec(32'h20000000, 1, 0, 1, 5'b00100); // addi
      add_vec(32'h24000000, 1, 0, 1, 5'b00100); // addiu
      add_vec(32'h28000000, 1, 0, 1, 5'b00100); // slti
      add_vec(32'h2C000000, 1, 0, 1, 5'b00100); // sltiu
      add_vec(32'h34000000, 1, 0, 1, 5'b00000); // ori
      add_vec(32'h8C000000, 0, 0, 0, 5'b00100); // lw invalid: extctr ungated
      add_vec(32'h10000000, 0, 0, 0, 5'b00000); // beq invalid
      add_vec(32'h42000018, 0, 0, 0, 5'b00000); // eret invalid

      // During reset: counters cleared, conditional lookup reads 0.
      #2;
      ifa.d_instr = 32'h10000000; ifa.d_valid = 1'b1;
      #1;
      chk("rst_br", {31'd0, ifa.br}, 32'd1);
      chk("rst_pred", {31'd0, ifa.pred_taken}, 32'd0);
      chk("rst_br_cnt", {28'd0, ifa.br_cnt}, 32'd0);
      chk("rst_miss_cnt", {28'd0, ifa.miss_cnt}, 32'd0);
      chk("rst_b_br_cnt", {28'd0, ifb.br_cnt}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      foreach (vq[i]) begin
         ifa.d_instr = vq[i].instr; ifa.d_valid = vq[i].valid;
         ifa.stall = vq[i].stall; ifa.d_pc = 32'h0;
         #1;
         act = {ifa.br, ifa.is_cond, ifa.extctr, ifa.pred_taken, ifa.Dclr};
         exp = vq[i].exp;
         if (!vq[i].chk_pred) begin
            act[1] = 1'b0;
            exp[1] = 1'b0;
         end
         chk($sformatf("vec%0d_%08h", i, vq[i].instr), {27'd0, act}, {27'd0, exp});
      end
      idle_all();
      @(posedge clk); #1;

      // Training and saturation at index of 0x3010.
      resolve(0, 32'h3010, 1, 1);
      lookup_a("train_01_to_10", 32'h3010, 1'b1);
      resolve(0, 32'h3010, 1, 1);
      lookup_a("train_11", 32'h3010, 1'b1);
      resolve(0, 32'h3010, 0, 0);
      lookup_a("train_10", 32'h3010, 1'b1);
      resolve(0, 32'h3010, 0, 0);
      lookup_a("train_01", 32'h3010, 1'b0);
      resolve(0, 32'h3010, 0, 0);
      lookup_a("train_00", 32'h3010, 1'b0);
      resolve(0, 32'h3010, 0, 0);
      lookup_a("train_00_sat", 32'h3010, 1'b0);
      resolve(0, 32'h3010, 1, 1);
      lookup_a("train_00_to_01", 32'h3010, 1'b0);
      resolve(0, 32'h3010, 1, 1);
      lookup_a("train_01_to_10b", 32'h3010, 1'b1);
      lookup_a("other_entry_untouched", 32'h3014, 1'b0);

      // Read-before-write at index 5.
      ifa.d_instr = 32'h10000000; ifa.d_pc = 32'h14; ifa.d_valid = 1'b1;
      ifa.e_resolve = 1'b1; ifa.e_pc = 32'h14; ifa.e_taken = 1'b1; ifa.e_pred = 1'b0;
      #1 chk("rbw_same_cycle", {31'd0, ifa.pred_taken}, 32'd0);
      chk("rbw_mispredict", {31'd0, ifa.mispredict}, 32'd1);
      @(posedge clk); #1;
      ifa.e_resolve = 1'b0;
      #1 chk("rbw_next_cycle", {31'd0, ifa.pred_taken}, 32'd1);
      @(posedge clk); #1;

      // 9 resolves so far, one of them mispredicted.
      chk("stat_br_9", {28'd0, ifa.br_cnt}, 32'd9);
      chk("stat_miss_1", {28'd0, ifa.miss_cnt}, 32'd1);
      ifa.e_taken = 1'b1; ifa.e_pred = 1'b0;
      #1 chk("no_resolve_no_miss", {31'd0, ifa.mispredict}, 32'd0);
      ifa.stat_clr = 1'b1;
      @(posedge clk); #1;
      ifa.stat_clr = 1'b0;
      chk("stat_clr_br", {28'd0, ifa.br_cnt}, 32'd0);

      for (int n = 0; n < 20; n++) begin
         ifa.e_resolve = 1'b1; ifa.e_pc = 32'h100; ifa.e_taken = 1'b1; ifa.e_pred = 1'b0;
         #1 chk($sformatf("miss_pulse%0d", n), {31'd0, ifa.mispredict}, 32'd1);
         @(posedge clk); #1;
         if (n == 9) chk("stat_br_10", {28'd0, ifa.br_cnt}, 32'd10);
      end
      ifa.e_resolve = 1'b0;
      chk("stat_br_sat", {28'd0, ifa.br_cnt}, 32'd15);
      chk("stat_miss_sat", {28'd0, ifa.miss_cnt}, 32'd15);
      ifa.e_resolve = 1'b1; ifa.e_taken = 1'b1; ifa.e_pred = 1'b1;
      #1 chk("correct_no_miss", {31'd0, ifa.mispredict}, 32'd0);
      @(posedge clk); #1;
      chk("stat_br_hold15", {28'd0, ifa.br_cnt}, 32'd15);
      ifa.e_pred = 1'b0; ifa.stat_clr = 1'b1;
      @(posedge clk); #1;
      ifa.stat_clr = 1'b0;
      chk("clr_prio_br", {28'd0, ifa.br_cnt}, 32'd0);
      chk("clr_prio_miss", {28'd0, ifa.miss_cnt}, 32'd0);
      @(posedge clk); #1;
      ifa.e_pred = 1'b1;
      @(posedge clk); #1;
      ifa.e_resolve = 1'b0;
      chk("after_clr_br", {28'd0, ifa.br_cnt}, 32'd2);
      chk("after_clr_miss", {28'd0, ifa.miss_cnt}, 32'd1);
      lookup_a("idx0_trained", 32'h0, 1'b1);

      // Aliasing on the 4-entry table: 0x0 and 0x10 share index 0.
      resolve(1, 32'h0, 1, 1);
      resolve(1, 32'h0, 1, 1);
      lookup_b("alias_0x10", 32'h10, 1'b1);
      lookup_b("alias_other_idx", 32'h4, 1'b0);
      ifb.d_pc = 32'h10;

      // Asynchronous reset between edges.
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      chk("async_pred_a", {31'd0, ifa.pred_taken}, 32'd0);
      chk("async_pred_b", {31'd0, ifb.pred_taken}, 32'd0);
      chk("async_br_cnt", {28'd0, ifa.br_cnt}, 32'd0);
      chk("async_miss_cnt", {28'd0, ifa.miss_cnt}, 32'd0);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      resolve(0, 32'h0, 1, 1);
      lookup_a("post_reset_01_to_10", 32'h0, 1'b1);
      resolve(1, 32'h10, 1, 1);
      lookup_b("post_reset_alias_0x0", 32'h0, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish, required finish before 50000");
      $fatal(1, "timeout");
   end
endmodule
